// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one request at a time to a registered ALU, waits out
// its result and zero-flag latency, and returns result/zero/tag over a
// valid/ready response port with backpressure.
// Optional build macro: ALU_ISSUE_FASTZ_EN -- zero flag computed locally from
// alu_out and captured one cycle earlier (in OUT), alu_z ignored.
module alu_issue_ctrl #(
  parameter int unsigned N     = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [N-1:0]     alu_in1,
  output logic [N-1:0]     alu_in2,
  output logic [2:0]       alu_op,
  input  logic [N-1:0]     alu_out,
  input  logic [15:0]      alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_OUT,
    S_ZWAIT,
    S_ERR
  } state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TAG_W-1:0] r_tag;
  logic             w_accept;
  logic             w_accept_op;
  logic             w_accept_ill;
  logic             w_slot;
  logic             w_cap_ok;
  logic             w_cap_err;
  logic             w_zero;
  logic             w_unused_z;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_slot    = !rsp_valid || rsp_ready;

`ifdef ALU_ISSUE_FASTZ_EN
  assign w_zero     = (alu_out == '0);
  assign w_unused_z = ^alu_z;
`else
  assign w_zero     = alu_z[0];
  assign w_unused_z = ^alu_z[15:1];
`endif

  // Next-state and capture/accept strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_accept_op  = 1'b0;
    w_accept_ill = 1'b0;
    w_cap_ok     = 1'b0;
    w_cap_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_op == OP_ILLEGAL) begin
            w_accept_ill = 1'b1;
            w_state_nxt  = S_ERR;
          end else begin
            w_accept_op = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: w_state_nxt = S_OUT;
      S_OUT: begin
`ifdef ALU_ISSUE_FASTZ_EN
        if (w_slot) begin
          w_cap_ok    = 1'b1;
          w_state_nxt = S_IDLE;
        end
`else
        w_state_nxt = S_ZWAIT;
`endif
      end
      S_ZWAIT: begin
`ifdef ALU_ISSUE_FASTZ_EN
        w_state_nxt = S_IDLE;
`else
        if (w_slot) begin
          w_cap_ok    = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_ERR: begin
        if (w_slot) begin
          w_cap_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ALU operand/opcode registers: only ever changed by a legal accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op  <= '0;
    end else if (w_accept_op) begin
      alu_in1 <= req_a;
      alu_in2 <= req_b;
      alu_op  <= req_op;
    end
  end

  // Tag latched on any accept, legal or illegal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_tag <= '0;
    else if (w_accept_op || w_accept_ill) r_tag <= req_tag;
  end

  // Response holding register; a capture on a consume edge replaces the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
    end else if (w_cap_ok) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_zero  <= w_zero;
      rsp_err   <= 1'b0;
      rsp_tag   <= r_tag;
    end else if (w_cap_err) begin
      rsp_valid <= 1'b1;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b1;
      rsp_tag   <= r_tag;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a behavioural registered ALU.
// Honours ALU_ISSUE_FASTZ_EN for the expected result latency.
module tb_alu_issue_ctrl;

  localparam int unsigned N     = 16;
  localparam int unsigned TAG_W = 4;
`ifdef ALU_ISSUE_FASTZ_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = '0;
  logic [N-1:0]     req_a = '0;
  logic [N-1:0]     req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [N-1:0]     alu_in1;
  logic [N-1:0]     alu_in2;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_out = '0;
  logic [15:0]      alu_z = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [N-1:0]     rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  int n_pass  = 0;
  int n_total = 0;
  int lat;

  alu_issue_ctrl #(.N(N), .TAG_W(TAG_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .rsp_tag   (rsp_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_f(input logic [2:0] op,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = a * b;
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return p[N-1:0];
      3'd4:    return a << b[3:0];
      3'd5:    return a << 1;
      3'd6:    return a >> 1;
      default: return a;
    endcase
  endfunction

  // Registered ALU model: result one cycle, zero flag one further cycle
  always @(posedge clk) begin
    alu_out <= alu_f(alu_op, alu_in1, alu_in2);
    alu_z   <= {15'b0, (alu_out == '0)};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns #1 after the accept edge
  task automatic issue(input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [TAG_W-1:0] tag);
    chk("issue_ready", {31'b0, req_ready}, 32'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < 10) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_rdy",   {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_in1",   {16'b0, alu_in1},   32'd0);
    chk("rst_in2",   {16'b0, alu_in2},   32'd0);
    chk("rst_op",    {29'b0, alu_op},    32'd0);
    chk("rst_data",  {16'b0, rsp_data},  32'd0);
    chk("rst_zero",  {31'b0, rsp_zero},  32'd0);
    chk("rst_err",   {31'b0, rsp_err},   32'd0);
    chk("rst_tag",   {28'b0, rsp_tag},   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // add 5+3, tag 2, checked cycle by cycle
    issue(3'd1, 16'd5, 16'd3, 4'd2);
    chk("add_in1", {16'b0, alu_in1}, 32'd5);
    chk("add_in2", {16'b0, alu_in2}, 32'd3);
    chk("add_op",  {29'b0, alu_op},  32'd1);
    chk("add_rdy0", {31'b0, req_ready}, 32'd0);
    for (int c = 1; c < LAT; c++) begin
      tick();
      chk("add_busy_valid", {31'b0, rsp_valid}, 32'd0);
      chk("add_busy_rdy",   {31'b0, req_ready}, 32'd0);
    end
    tick();
    chk("add_valid", {31'b0, rsp_valid}, 32'd1);
    chk("add_data",  {16'b0, rsp_data},  32'd8);
    chk("add_zero",  {31'b0, rsp_zero},  32'd0);
    chk("add_err",   {31'b0, rsp_err},   32'd0);
    chk("add_tag",   {28'b0, rsp_tag},   32'd2);
    chk("add_rdy1",  {31'b0, req_ready}, 32'd1);
    tick();
    chk("add_drain", {31'b0, rsp_valid}, 32'd0);

    // sub 7-7 -> zero
    issue(3'd2, 16'd7, 16'd7, 4'd3);
    wait_rsp(lat);
    chk("sub_lat",  lat, LAT);
    chk("sub_data", {16'b0, rsp_data}, 32'd0);
    chk("sub_zero", {31'b0, rsp_zero}, 32'd1);
    chk("sub_tag",  {28'b0, rsp_tag},  32'd3);
    tick();

    // mul 0x0100*0x0100 truncates to zero
    issue(3'd3, 16'h0100, 16'h0100, 4'd6);
    wait_rsp(lat);
    chk("mul_lat",  lat, LAT);
    chk("mul_data", {16'b0, rsp_data}, 32'd0);
    chk("mul_zero", {31'b0, rsp_zero}, 32'd1);
    chk("mul_err",  {31'b0, rsp_err},  32'd0);
    tick();

    // shr1 on a nonzero value
    issue(3'd6, 16'h0F0F, 16'h0000, 4'd7);
    wait_rsp(lat);
    chk("shr_data", {16'b0, rsp_data}, 32'h0787);
    chk("shr_zero", {31'b0, rsp_zero}, 32'd0);
    tick();

    // illegal op: ALU ports keep shr1 values
    issue(3'd7, 16'hAAAA, 16'h5555, 4'd9);
    chk("ill_in1", {16'b0, alu_in1}, 32'h0F0F);
    chk("ill_in2", {16'b0, alu_in2}, 32'h0000);
    chk("ill_op",  {29'b0, alu_op},  32'd6);
    wait_rsp(lat);
    chk("ill_lat",  lat, 1);
    chk("ill_err",  {31'b0, rsp_err},  32'd1);
    chk("ill_data", {16'b0, rsp_data}, 32'd0);
    chk("ill_zero", {31'b0, rsp_zero}, 32'd0);
    chk("ill_tag",  {28'b0, rsp_tag},  32'd9);
    tick();

    // Backpressure: first response held, second stalls then replaces it
    rsp_ready = 1'b0;
    issue(3'd1, 16'd2, 16'd3, 4'd1);
    wait_rsp(lat);
    chk("bp1_lat",  lat, LAT);
    chk("bp1_data", {16'b0, rsp_data}, 32'd5);
    issue(3'd1, 16'd1, 16'd1, 4'd4);
    repeat (5) tick();
    chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_data",  {16'b0, rsp_data},  32'd5);
    chk("bp_tag",   {28'b0, rsp_tag},   32'd1);
    chk("bp_rdy",   {31'b0, req_ready}, 32'd0);
    chk("bp_in1",   {16'b0, alu_in1},   32'd1);
    chk("bp_in2",   {16'b0, alu_in2},   32'd1);
    chk("bp_op",    {29'b0, alu_op},    32'd1);
    rsp_ready = 1'b1;
    tick();
    chk("bp2_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp2_data",  {16'b0, rsp_data},  32'd2);
    chk("bp2_tag",   {28'b0, rsp_tag},   32'd4);
    chk("bp2_rdy",   {31'b0, req_ready}, 32'd1);
    tick();
    chk("bp2_drain", {31'b0, rsp_valid}, 32'd0);

    // Reset while in OUT abandons the operation
    issue(3'd1, 16'd4, 16'd4, 4'd3);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mrst_rdy",   {31'b0, req_ready}, 32'd1);
    chk("mrst_in1",   {16'b0, alu_in1},   32'd0);
    chk("mrst_op",    {29'b0, alu_op},    32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mrst_norsp", {31'b0, rsp_valid}, 32'd0);
    issue(3'd1, 16'd6, 16'd9, 4'd5);
    wait_rsp(lat);
    chk("post_lat",  lat, LAT);
    chk("post_data", {16'b0, rsp_data}, 32'd15);
    chk("post_tag",  {28'b0, rsp_tag},  32'd5);
    chk("post_zero", {31'b0, rsp_zero}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage that sits directly upstream of the registered ALU and also consumes its result.
- Accepts one operation request at a time over a valid/ready handshake and drives the ALU operand and opcode ports, holding them stable.
- Waits out the ALU's one-cycle result latency and its further one-cycle zero-flag latency.
- Returns result, zero flag and tag over a valid/ready response port with backpressure.

Parameters:
- N, 16, datapath width; matches the ALU's N.
- TAG_W, 4, width of the request/response tag.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_op  input  3  ALU opcode: 0 pass, 1 add, 2 sub, 3 mul, 4 shift by width_of_i, 5 shl1, 6 shr1, 7 illegal.
- req_a  input  N  operand 1.
- req_b  input  N  operand 2.
- req_tag  input  TAG_W  opaque tag returned with the response.
- alu_in1  output  N  to ALU in1.
- alu_in2  output  N  to ALU in2.
- alu_op  output  3  to ALU alu_op.
- alu_out  input  N  from ALU, registered result.
- alu_z  input  16  from ALU zero flag; only bit 0 is used.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer takes response.
- rsp_data  output  N  captured result.
- rsp_zero  output  1  captured zero flag.
- rsp_err  output  1  response is for an illegal opcode.
- rsp_tag  output  TAG_W  tag of the request.

Behaviour:
- Reset (async, rst_n=0): state IDLE; alu_in1=0, alu_in2=0, alu_op=0; rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, rsp_tag=0. Reset mid-operation abandons the operation; no response is produced.
- req_ready = (state==IDLE), combinational from state only.
- Accept occurs on an edge where req_valid and req_ready are both 1.
  - At accept edge k with req_op 0..6: alu_in1<=req_a, alu_in2<=req_b, alu_op<=req_op, tag latched; go to EXEC.
  - At accept with req_op 7: ALU ports unchanged, tag latched; go to ERR.
- EXEC -> OUT -> ZWAIT, one cycle each, unconditional.
  - ALU registers alu_out at edge k+1.
  - ALU registers z from that alu_out at edge k+2.
- ZWAIT: capture at an edge where (!rsp_valid || rsp_ready).
  - Captured values: rsp_data<=alu_out, rsp_zero<=alu_z[0], rsp_err<=0, rsp_tag<=tag, rsp_valid<=1; go to IDLE.
  - Otherwise stay in ZWAIT. ALU ports are held, so alu_out and alu_z stay stable.
- ERR: capture under the same slot condition with rsp_data<=0, rsp_zero<=0, rsp_err<=1; go to IDLE.
- Latency with no backpressure: accept at edge k, rsp_valid high after edge k+3. Throughput is one operation per 4 cycles.
- ALU ports keep their last values between operations; they are never changed outside an accept.
- rsp_valid clears on an edge where rsp_ready=1, unless a capture occurs on the same edge, in which case the new response replaces the old one and rsp_valid stays 1.
- rsp_* are stable while rsp_valid=1 and rsp_ready=0.
- Result width: rsp_data is exactly N bits as produced by the ALU. Multiply overflow is truncated by the ALU and not flagged here.

Optional Feature:
- Macro ALU_ISSUE_FASTZ_EN.
- Defined: the OUT state is the capture state. rsp_zero is computed locally as (alu_out=={N{1'b0}}) and alu_z is ignored. Latency is accept edge k, rsp_valid after edge k+2, one operation per 3 cycles. Backpressure stall occurs in OUT.
- Undefined: behaviour exactly as above, using ZWAIT and alu_z[0].

Test Plan:
- After reset, check outputs: all outputs at reset values, req_ready=1.
- add, a=5, b=3, tag=2, rsp_ready=1 -> rsp_valid 3 cycles after accept, data=8, zero=0, err=0, tag=2; req_ready low for 3 cycles.
- sub, a=7, b=7 -> data=0, zero=1. mul, a=0x0100, b=0x0100 (N=16) -> data=0x0000, zero=1.
- Op 7 with tag=9 -> err=1, data=0, tag=9; alu_op/alu_in unchanged from the previous op.
- Backpressure: hold rsp_ready=0 after the first response and issue a second add 1+1. The controller stalls in ZWAIT with ALU ports stable and req_ready=0. Raising rsp_ready gives the first response consumed and the second captured on the same edge (data=2), with rsp_valid staying 1.
- Pull rst_n low during OUT -> immediate reset values, no response; the next request completes normally. Repeat the add test with ALU_ISSUE_FASTZ_EN defined -> latency 2 cycles.
